// File: rtl/ram4bank_ctrl_if.sv
// Pixel-in / quad-out stream bundle for ram4bank_ctrl.
// slave = controller side, master = upstream pixel source and downstream quad sink.
interface ram4bank_ctrl_if;
  logic        s_valid;
  logic        s_ready;
  logic [7:0]  s_data;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_data;

  modport slave  (input  s_valid, s_data, m_ready, output s_ready, m_valid, m_data);
  modport master (output s_valid, s_data, m_ready, input  s_ready, m_valid, m_data);
endinterface

// File: rtl/ram4bank_ctrl.sv
// Write/read sequencer for the 4-bank pixel store: scatters a raster frame by (x,y) parity,
// then streams 2x2 quads from all banks in parallel. RAM4BANK_SLIDE_EN selects a stride-1 window.
module ram4bank_ctrl #(
  parameter int unsigned IMG_W  = 128,
  parameter int unsigned IMG_H  = 128,
  parameter int unsigned ADDR_W = 13
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  ram4bank_ctrl_if.slave    stream,
  output logic              ena1, ena2, ena3, ena4,
  output logic              wea1, wea2, wea3, wea4,
  output logic [ADDR_W-1:0] AA1, AA2, AA3, AA4,
  output logic [7:0]        DA1, DA2, DA3, DA4,
  output logic              enb,
  output logic              rstb,
  output logic [ADDR_W-1:0] AB1, AB2, AB3, AB4,
  input  logic [7:0]        DB1, DB2, DB3, DB4,
  input  logic              rsta_busy,
  input  logic              rstb_busy
);

  localparam int unsigned     XW     = $clog2(IMG_W);
  localparam int unsigned     YW     = $clog2(IMG_H);
  localparam logic [ADDR_W-1:0] HALF_W = ADDR_W'(IMG_W / 2);

  typedef enum logic [2:0] {ST_INIT, ST_IDLE, ST_WR, ST_DRAIN, ST_RD} state_t;

  state_t state, state_nxt;

  logic              hs_w, last_px;
  logic [XW-1:0]     wx;
  logic [YW-1:0]     wy;
  logic [ADDR_W-1:0] wrow;
  logic [3:0]        wen_q;
  logic [ADDR_W-1:0] waddr_q;
  logic [7:0]        wdata_q;

  logic              m_valid_q, adv, issue, rd_all, rd_last, fin;
  logic [31:0]       m_data_c;

  assign hs_w    = stream.s_valid && stream.s_ready;
  assign last_px = (wx == XW'(IMG_W - 1)) && (wy == YW'(IMG_H - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_INIT;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b1;
    case (state)
      ST_INIT:  if (!(rsta_busy || rstb_busy)) state_nxt = ST_IDLE;
      ST_IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = ST_WR;
      end
      ST_WR:    if (hs_w && last_px) state_nxt = ST_DRAIN;
      ST_DRAIN: state_nxt = ST_RD;
      ST_RD:    if (fin) state_nxt = ST_IDLE;
      default:  state_nxt = ST_INIT;
    endcase
  end

  assign stream.s_ready = (state == ST_WR);

  // Write address = row base (+IMG_W/2 after every odd row) + x/2; no multiplier.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wx   <= '0;
      wy   <= '0;
      wrow <= '0;
    end else if (hs_w) begin
      if (wx == XW'(IMG_W - 1)) begin
        wx <= '0;
        if (wy == YW'(IMG_H - 1)) begin
          wy   <= '0;
          wrow <= '0;
        end else begin
          wy <= wy + 1'b1;
          if (wy[0]) wrow <= wrow + HALF_W;
        end
      end else begin
        wx <= wx + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wen_q   <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else if (hs_w) begin
      wen_q   <= 4'b0001 << {wy[0], wx[0]};
      waddr_q <= wrow + ADDR_W'(wx >> 1);
      wdata_q <= stream.s_data;
    end else begin
      wen_q   <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
    end
  end

  assign ena1 = wen_q[0];
  assign ena2 = wen_q[1];
  assign ena3 = wen_q[2];
  assign ena4 = wen_q[3];
  assign wea1 = wen_q[0];
  assign wea2 = wen_q[1];
  assign wea3 = wen_q[2];
  assign wea4 = wen_q[3];
  assign AA1  = wen_q[0] ? waddr_q : '0;
  assign AA2  = wen_q[1] ? waddr_q : '0;
  assign AA3  = wen_q[2] ? waddr_q : '0;
  assign AA4  = wen_q[3] ? waddr_q : '0;
  assign DA1  = wen_q[0] ? wdata_q : '0;
  assign DA2  = wen_q[1] ? wdata_q : '0;
  assign DA3  = wen_q[2] ? wdata_q : '0;
  assign DA4  = wen_q[3] ? wdata_q : '0;

  // The bank output register is the only read stage, so a stalled quad holds simply by gating enb.
  assign adv   = !m_valid_q || stream.m_ready;
  assign enb   = adv && (state == ST_RD);
  assign issue = enb && !rd_all;
  assign fin   = (state == ST_RD) && rd_all && m_valid_q && stream.m_ready;
  assign done  = fin;
  assign rstb  = 1'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   m_valid_q <= 1'b0;
    else if (adv) m_valid_q <= issue;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                rd_all <= 1'b0;
    else if (fin)              rd_all <= 1'b0;
    else if (issue && rd_last) rd_all <= 1'b1;
  end

`ifdef RAM4BANK_SLIDE_EN
  logic [XW-1:0]     rx;
  logic [YW-1:0]     ry;
  logic [ADDR_W-1:0] rrow, rcol, row_up, col_up;
  logic              x0_q, y0_q;
  logic [7:0]        db [4];

  assign rd_last = (rx == XW'(IMG_W - 2)) && (ry == YW'(IMG_H - 2));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx   <= '0;
      ry   <= '0;
      rrow <= '0;
      x0_q <= 1'b0;
      y0_q <= 1'b0;
    end else if (issue) begin
      x0_q <= rx[0];
      y0_q <= ry[0];
      if (rx == XW'(IMG_W - 2)) begin
        rx <= '0;
        if (ry == YW'(IMG_H - 2)) begin
          ry   <= '0;
          rrow <= '0;
        end else begin
          ry <= ry + 1'b1;
          if (ry[0]) rrow <= rrow + HALF_W;
        end
      end else begin
        rx <= rx + 1'b1;
      end
    end
  end

  // An even-parity bank lies one pixel ahead of an odd window origin, i.e. one word further on.
  assign rcol   = ADDR_W'(rx >> 1);
  assign col_up = rcol + ADDR_W'(rx[0]);
  assign row_up = rrow + (ry[0] ? HALF_W : '0);

  assign AB1 = row_up + col_up;
  assign AB2 = row_up + rcol;
  assign AB3 = rrow   + col_up;
  assign AB4 = rrow   + rcol;

  assign db[0] = DB1;
  assign db[1] = DB2;
  assign db[2] = DB3;
  assign db[3] = DB4;

  always_comb begin
    m_data_c = '0;
    for (int unsigned l = 0; l < 4; l++)
      m_data_c[8*l +: 8] = db[2'(l) ^ {y0_q, x0_q}];
  end
`else
  logic [ADDR_W-1:0] rd_addr;

  assign rd_last = (rd_addr == ADDR_W'(IMG_W * IMG_H / 4 - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     rd_addr <= '0;
    else if (issue) rd_addr <= rd_last ? '0 : rd_addr + 1'b1;
  end

  assign AB1 = rd_addr;
  assign AB2 = rd_addr;
  assign AB3 = rd_addr;
  assign AB4 = rd_addr;

  assign m_data_c = {DB4, DB3, DB2, DB1};
`endif

  assign stream.m_valid = m_valid_q;
  assign stream.m_data  = m_data_c;

endmodule

// File: tb/tb_ram4bank_ctrl.sv
// Self-checking bench for ram4bank_ctrl (4x4 frame) with a behavioural bank model and quad reference.
// Build with RAM4BANK_SLIDE_EN defined to check the stride-1 window variant.
module tb_ram4bank_ctrl;
  localparam int W    = 4;
  localparam int H    = 4;
  localparam int AW   = 13;
  localparam int NPIX = W * H;
`ifdef RAM4BANK_SLIDE_EN
  localparam int NQ   = (W - 1) * (H - 1);
  localparam int STEP = 1;
`else
  localparam int NQ   = W * H / 4;
  localparam int STEP = 2;
`endif

  logic          clk, rst_n, start, busy, done;
  logic          ena1, ena2, ena3, ena4, wea1, wea2, wea3, wea4;
  logic [AW-1:0] AA1, AA2, AA3, AA4, AB1, AB2, AB3, AB4;
  logic [7:0]    DA1, DA2, DA3, DA4, DB1, DB2, DB3, DB4;
  logic          enb, rstb, rsta_busy, rstb_busy;

  ram4bank_ctrl_if bus ();

  ram4bank_ctrl #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .stream(bus),
    .ena1(ena1), .ena2(ena2), .ena3(ena3), .ena4(ena4),
    .wea1(wea1), .wea2(wea2), .wea3(wea3), .wea4(wea4),
    .AA1(AA1), .AA2(AA2), .AA3(AA3), .AA4(AA4),
    .DA1(DA1), .DA2(DA2), .DA3(DA3), .DA4(DA4),
    .enb(enb), .rstb(rstb),
    .AB1(AB1), .AB2(AB2), .AB3(AB3), .AB4(AB4),
    .DB1(DB1), .DB2(DB2), .DB3(DB3), .DB4(DB4),
    .rsta_busy(rsta_busy), .rstb_busy(rstb_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural banks: port-A write, port-B registered read held while enb=0.
  logic [7:0] mem [4][8192];
  always @(posedge clk) begin
    if (ena1 && wea1) mem[0][AA1] <= DA1;
    if (ena2 && wea2) mem[1][AA2] <= DA2;
    if (ena3 && wea3) mem[2][AA3] <= DA3;
    if (ena4 && wea4) mem[3][AA4] <= DA4;
    if (enb) begin
      DB1 <= mem[0][AB1];
      DB2 <= mem[1][AB2];
      DB3 <= mem[2][AB3];
      DB4 <= mem[3][AB4];
    end
  end

  logic [3:0] ena_v, wea_v;
  logic       porta_any;
  assign ena_v     = {ena4, ena3, ena2, ena1};
  assign wea_v     = {wea4, wea3, wea2, wea1};
  assign porta_any = |{ena_v, wea_v, AA1, AA2, AA3, AA4, DA1, DA2, DA3, DA4};

  typedef struct { logic [7:0] pix; int bank; int addr; } wvec_t;
  typedef struct { logic [31:0] quad; logic last; } qvec_t;
  wvec_t wtab [NPIX];
  qvec_t qtab [NQ];

  logic [7:0]  img   [NPIX];
  logic [31:0] exp_q [NQ];
  logic [31:0] got_q [NQ];
  logic        got_d [NQ];
  int          got_n;
  int          n_chk = 0;
  int          n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h @%0t", name, act, req, $time);
    end
  endtask

  function automatic logic [31:0] aa_sel(input int b);
    case (b)
      0: return 32'(AA1);
      1: return 32'(AA2);
      2: return 32'(AA3);
      default: return 32'(AA4);
    endcase
  endfunction

  function automatic logic [31:0] da_sel(input int b);
    case (b)
      0: return 32'(DA1);
      1: return 32'(DA2);
      2: return 32'(DA3);
      default: return 32'(DA4);
    endcase
  endfunction

  // Reference: pixel (x,y) lives in bank {y%2,x%2} at word (y/2)*(W/2)+x/2.
  task automatic chk_porta(input logic acc, input int idx);
    int x, y, b;
    if (acc) begin
      x = idx % W;
      y = idx / W;
      b = (y % 2) * 2 + (x % 2);
      chk("porta_en", 32'(ena_v), 32'(1 << b));
      chk("porta_we", 32'(wea_v), 32'(1 << b));
      chk("porta_addr", aa_sel(b), 32'((y / 2) * (W / 2) + x / 2));
      chk("porta_data", da_sel(b), 32'(img[idx]));
    end else begin
      chk("porta_idle", 32'(porta_any), 32'd0);
    end
  endtask

  task automatic build_exp();
    int k;
    k = 0;
    for (int y = 0; y <= H - 2; y += STEP)
      for (int x = 0; x <= W - 2; x += STEP) begin
        exp_q[k] = {img[(y+1)*W + x+1], img[(y+1)*W + x], img[y*W + x+1], img[y*W + x]};
        k++;
      end
  endtask

  task automatic wait_idle(input string name);
    int cyc;
    cyc = 0;
    while (busy && cyc < 50) begin
      @(negedge clk);
      #2;
      cyc++;
    end
    chk(name, 32'(busy), 32'd0);
  endtask

  task automatic write_frame(input int vmode);
    int idx, cyc, pidx;
    logic acc, pacc;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    idx = 0; cyc = 0; pacc = 1'b0; pidx = 0;
    while (idx < NPIX && cyc < 500) begin
      bus.s_valid = (vmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      bus.s_data  = bus.s_valid ? img[idx] : 8'($urandom);
      #2;
      chk_porta(pacc, pidx);
      acc  = bus.s_valid && bus.s_ready;
      pacc = acc;
      pidx = idx;
      @(negedge clk);
      cyc++;
      if (acc) idx++;
    end
    bus.s_valid = 1'b0;
    chk("write_count", 32'(idx), 32'(NPIX));
    #2 chk_porta(pacc, pidx);
    @(negedge clk);
  endtask

  task automatic collect(input int rmode);
    int cyc;
    logic stalled;
    logic [31:0] held;
    for (int i = 0; i < NQ; i++) begin
      got_q[i] = 32'hDEADBEEF;
      got_d[i] = 1'b0;
    end
    got_n = 0; cyc = 0; stalled = 1'b0; held = '0;
    while (got_n < NQ && cyc < 500) begin
      case (rmode)
        0:       bus.m_ready = 1'b1;
        1:       bus.m_ready = (cyc % 2 == 0);
        default: bus.m_ready = 1'($urandom_range(0, 1));
      endcase
      #2;
      chk("s_ready_rd", 32'(bus.s_ready), 32'd0);
      if (stalled) begin
        chk("stall_valid", 32'(bus.m_valid), 32'd1);
        chk("stall_data", bus.m_data, held);
      end
      if (bus.m_valid && bus.m_ready) begin
        got_q[got_n] = bus.m_data;
        got_d[got_n] = done;
        got_n++;
      end else begin
        chk("done_quiet", 32'(done), 32'd0);
      end
      stalled = bus.m_valid && !bus.m_ready;
      held    = bus.m_data;
      @(negedge clk);
      cyc++;
    end
    bus.m_ready = 1'b0;
    chk("read_count", 32'(got_n), 32'(NQ));
    #2 chk("idle_after_rd", 32'({busy, bus.m_valid}), 32'd0);
  endtask

  task automatic compare_tab();
    for (int i = 0; i < NQ; i++) begin
      chk("quad_tab", got_q[i], qtab[i].quad);
      chk("done_tab", 32'(got_d[i]), 32'(qtab[i].last));
    end
  endtask

  task automatic compare_model();
    build_exp();
    for (int i = 0; i < NQ; i++) begin
      chk("quad_model", got_q[i], exp_q[i]);
      chk("done_model", 32'(got_d[i]), 32'(i == NQ - 1));
    end
    chk("bank1_first", 32'(mem[0][0]), 32'(img[0]));
    chk("bank4_last", 32'(mem[3][(H/2 - 1) * (W/2) + W/2 - 1]), 32'(img[NPIX-1]));
  endtask

  task automatic ramp();
    for (int i = 0; i < NPIX; i++) img[i] = 8'(i);
  endtask

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: actual=timeout required=finish");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic saw;
    int   k;

    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        wtab[y*W + x] = '{8'(y*W + x), (y % 2) * 2 + (x % 2), (y / 2) * 2 + x / 2};
`ifdef RAM4BANK_SLIDE_EN
    qtab = '{'{32'h05040100, 1'b0}, '{32'h06050201, 1'b0}, '{32'h07060302, 1'b0},
             '{32'h09080504, 1'b0}, '{32'h0A090605, 1'b0}, '{32'h0B0A0706, 1'b0},
             '{32'h0D0C0908, 1'b0}, '{32'h0E0D0A09, 1'b0}, '{32'h0F0E0B0A, 1'b1}};
`else
    qtab = '{'{32'h05040100, 1'b0}, '{32'h07060302, 1'b0},
             '{32'h0D0C0908, 1'b0}, '{32'h0F0E0B0A, 1'b1}};
`endif

    // Reset with port-A reset busy held: start must be ignored while in INIT.
    rst_n = 1'b0; rsta_busy = 1'b1; rstb_busy = 1'b0; start = 1'b0;
    bus.s_valid = 1'b0; bus.s_data = '0; bus.m_ready = 1'b0;
    #23;
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_outs", 32'({done, bus.s_ready, bus.m_valid, enb, rstb}), 32'd0);
    chk("rst_porta", 32'(porta_any), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      start = (c == 5);
      #2 chk("init_hold", 32'({busy, bus.s_ready}), 32'b10);
    end
    @(negedge clk); start = 1'b0; rsta_busy = 1'b0;
    #2 wait_idle("init_exit");
    @(negedge clk);
    #2 chk("start_ignored", 32'({busy, bus.s_ready}), 32'd0);

    // 4x4 ramp written from the port-A vector table, then read at full rate.
    ramp();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < NPIX; i++) begin
      bus.s_valid = 1'b1;
      bus.s_data  = wtab[i].pix;
      #2;
      chk("wtab_ready", 32'(bus.s_ready), 32'd1);
      if (i > 0) begin
        chk("wtab_en", 32'(ena_v), 32'(1 << wtab[i-1].bank));
        chk("wtab_addr", aa_sel(wtab[i-1].bank), 32'(wtab[i-1].addr));
        chk("wtab_data", da_sel(wtab[i-1].bank), 32'(wtab[i-1].pix));
      end
      @(negedge clk);
    end
    bus.s_valid = 1'b0;
    #2;
    chk("wtab_en", 32'(ena_v), 32'(1 << wtab[NPIX-1].bank));
    chk("wtab_addr", aa_sel(wtab[NPIX-1].bank), 32'(wtab[NPIX-1].addr));
    chk("wtab_data", da_sel(wtab[NPIX-1].bank), 32'(wtab[NPIX-1].pix));
    chk("drain_ready", 32'(bus.s_ready), 32'd0);
    @(negedge clk);
    collect(0);
    compare_tab();

    // Same frame, sink toggling ready.
    write_frame(0);
    collect(1);
    compare_tab();

    // Random frames, random valid and ready, against the reference quads.
    for (int f = 0; f < 4; f++) begin
      for (int i = 0; i < NPIX; i++) img[i] = 8'($urandom);
      write_frame(1);
      collect(2);
      compare_model();
    end

    // Reset in the middle of the read phase, then a clean frame.
    ramp();
    write_frame(1);
    saw = 1'b0; k = 0;
    while (!saw && k < 50) begin
      bus.m_ready = 1'b1;
      #2;
      if (bus.m_valid && k > 1) saw = 1'b1;
      else begin
        @(negedge clk);
        k++;
      end
    end
    chk("rd_reached", 32'(saw), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", 32'({bus.m_valid, done, enb}), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd1);
    chk("midrst_porta", 32'(porta_any), 32'd0);
    bus.m_ready = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    #2 wait_idle("midrst_idle");
    write_frame(0);
    collect(0);
    compare_tab();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
